muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the EX stage, beside the ALU.
//  Takes the same forwarded operands (port_A/port_B) as the ALU.
//  Executes MULT/MULTU/DIV/DIVU over multiple cycles and writes the HI/LO pair read by MFHI/MFLO.
//  Hazard logic stalls the pipeline while busy=1.
// PARAMETERS
//  WORD_W     32  operand/result width; must equal word_t width
//  STEP_BITS  1   quotient/multiplier bits retired per CALC cycle; must divide WORD_W (1,2,4)
// PORTS
//  CLK          in   1       clock, rising edge
//  nRST         in   1       asynchronous active-low reset
//  start        in   1       request; sampled only in IDLE or DONE
//  md_op        in   2       muldiv_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
//  flush        in   1       synchronous abort (branch/exception squash)
//  port_A       in   WORD_W  multiplicand / dividend
//  port_B       in   WORD_W  multiplier / divisor
//  busy         out  1       high in CALC and SIGN
//  done         out  1       one-cycle pulse in DONE; hi/lo valid from this cycle
//  hi           out  WORD_W  MULT: product[63:32]; DIV: remainder
//  lo           out  WORD_W  MULT: product[31:0]; DIV: quotient
//  div_zero     out  1       registered with hi/lo; 1 if last DIV/DIVU had port_B==0
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, div_zero = 0; hi, lo = 0. Internal accumulators are cleared.
//  - FSM: IDLE -> CALC -> SIGN -> DONE -> IDLE.
//    - IDLE/DONE + start & !flush: go to CALC.
//    - Latch md_op. For signed ops, latch |port_A| and |port_B| plus both sign bits.
//    - Load count = WORD_W/STEP_BITS (N).
//  - CALC: each cycle retires STEP_BITS bits via shift-add (mult) or restoring shift-subtract (div). count decrements; after N cycles, go to SIGN.
//  - SIGN: apply the sign fix for signed ops, then register hi/lo/div_zero and go to DONE.
//    - Product is negated (64-bit two's complement) iff the operand signs differ.
//    - Quotient is negated iff the signs differ.
//    - Remainder takes the sign of the dividend.
//  - DONE: done=1, busy=0 for exactly one cycle. start here is accepted (back-to-back); otherwise go to IDLE.
//  - Latency: start sampled at edge 0 -> done=1 in the cycle after edge N+2 (34 cycles at defaults).
//  - hi/lo change only on the SIGN->DONE edge and hold until the next completion.
//  - start while busy: ignored, no queueing.
//  - flush: any state -> IDLE next edge. No done pulse; hi/lo/div_zero unchanged. flush wins over a simultaneous start.
//  - Divide by zero: full latency is kept; hi=port_A (as latched), lo=32'hFFFFFFFF, div_zero=1. Signedness is ignored.
//  - Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
//  - nRST mid-operation: immediate return to reset values; no done.
//  - MULT/MULTU also clear div_zero on completion.
// CONFIGURATION
//  MULDIV_EARLY_EXIT_EN
//   - Defined: in CALC for MULT/MULTU, if the remaining unshifted multiplier bits are all 0, go to SIGN on the next edge.
//     The accumulator is shifted to its final alignment in that step. Latency is variable, minimum 3.
//     Division is unaffected.
//   - Undefined: fixed latency N+2 for all ops. The bench checks exact cycle counts only in this build.
// STRUCTURE
//  - cpu_types_pkg gains:
//    - typedef enum logic [1:0] muldiv_op_t {MD_MULT=2'b00, MD_MULTU, MD_DIV, MD_DIVU}
//    - typedef enum logic [1:0] md_state_t {MD_IDLE, MD_CALC, MD_SIGN, MD_DONE}
//  - muldiv_if interface, with modports md and tb mirroring the port list above.
//  - Sub-module muldiv_step: combinational, one STEP_BITS iteration.
//    Inputs: acc, operand, mode. Outputs: next acc.
//    Instantiated once; muldiv_unit owns all state.
// TESTING
//  1 Reset: nRST=0 mid-CALC -> busy=0, done=0, hi=lo=0 immediately; no done pulse after release.
//  2 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start.
//  3 MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//    DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    DIVU 7/2 -> lo=3, hi=1.
//  4 DIV 100/0 -> hi=100, lo=0xFFFFFFFF, div_zero=1.
//    Then MULT 2*2 -> lo=4, div_zero=0.
//  5 flush at CALC cycle 10 with start high -> IDLE, no done, hi/lo keep prior values.
//    start during busy -> ignored.
//  6 Back-to-back: start held during DONE -> second op accepted; second done exactly 34 cycles after that DONE cycle.
//    DIV 0x80000000/-1 -> lo=0x80000000, hi=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, multiply/divide opcodes and the mul/div FSM states.
package cpu_types_pkg;
    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;
    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_SIGN, MD_DONE} md_state_t;

    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Magnitude of x when en is set; 0x80000000 maps to itself, which the unsigned core reads correctly.
    function automatic word_t abs_word(input word_t x, input logic en);
        return (en && x[XLEN-1]) ? -x : x;
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// Handshake/operand bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_if;
    import cpu_types_pkg::*;

    logic       start;
    muldiv_op_t md_op;
    logic       flush;
    word_t      port_A;
    word_t      port_B;
    logic       busy;
    logic       done;
    word_t      hi;
    word_t      lo;
    logic       div_zero;

    modport md (input start, md_op, flush, port_A, port_B,
                output busy, done, hi, lo, div_zero);
    modport tb (output start, md_op, flush, port_A, port_B,
                input busy, done, hi, lo, div_zero);
endinterface

// File: rtl/muldiv_step.sv
// One CALC iteration: STEP_BITS rounds of shift-add (multiply) or restoring shift-subtract (divide).
module muldiv_step #(
    parameter int WORD_W    = 32,
    parameter int STEP_BITS = 1
) (
    input  logic [2*WORD_W-1:0] i_acc,
    input  logic [WORD_W-1:0]   i_operand,
    input  logic                i_is_div,
    output logic [2*WORD_W-1:0] o_acc
);
    logic [2*WORD_W-1:0] w_acc;
    logic [WORD_W:0]     w_rem;
    logic [WORD_W:0]     w_sum;
    logic [WORD_W-1:0]   w_diff;
    logic                w_ge;

    // acc = {upper, lower}: multiply keeps the partial product above the unconsumed multiplier,
    // divide keeps the partial remainder above the dividend/quotient shift register.
    always_comb begin
        w_acc  = i_acc;
        w_rem  = '0;
        w_sum  = '0;
        w_diff = '0;
        w_ge   = 1'b0;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (i_is_div) begin
                w_rem  = {w_acc[2*WORD_W-1:WORD_W], w_acc[WORD_W-1]};
                w_ge   = (w_rem >= {1'b0, i_operand});
                w_diff = w_rem[WORD_W-1:0] - i_operand;
                w_acc  = {(w_ge ? w_diff : w_rem[WORD_W-1:0]), w_acc[WORD_W-2:0], w_ge};
            end else begin
                w_sum = {1'b0, w_acc[2*WORD_W-1:WORD_W]} + (w_acc[0] ? {1'b0, i_operand} : '0);
                w_acc = {w_sum, w_acc[WORD_W-1:1]};
            end
        end
        o_acc = w_acc;
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO; sign handled by magnitude core plus final fix-up.
// Optional MULDIV_EARLY_EXIT_EN lets multiplies finish once the remaining multiplier bits are zero.
//
//   state   | meaning
//   MD_IDLE | waiting for start
//   MD_CALC | retiring STEP_BITS bits per cycle until count reaches 0
//   MD_SIGN | sign fix-up, HI/LO/div_zero registered on exit
//   MD_DONE | one-cycle done pulse; a new start is accepted here
module muldiv_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W    = XLEN,
    parameter int STEP_BITS = 1
) (
    input logic CLK,
    input logic nRST,
    muldiv_if.md bus
);
    localparam int N     = WORD_W / STEP_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    md_state_t           r_state, w_next;
    muldiv_op_t          r_op;
    logic [2*WORD_W-1:0] r_acc, w_step_acc, w_prod;
    logic [WORD_W-1:0]   r_opnd, r_hi, r_lo, w_hi, w_lo, w_quo, w_rem, w_abs_a, w_abs_b;
    logic [CNT_W-1:0]    r_count;
    logic                r_sa, r_sb, r_div_zero;
    logic                w_load, w_calc, w_fin, w_early;
    logic                w_is_div, w_is_signed, w_neg_res, w_dz, w_ld_signed, w_ld_div;

    assign w_ld_signed = is_signed_op(bus.md_op);
    assign w_ld_div    = bus.md_op[1];
    assign w_abs_a     = abs_word(bus.port_A, w_ld_signed);
    assign w_abs_b     = abs_word(bus.port_B, w_ld_signed);
    assign w_is_div    = r_op[1];
    assign w_is_signed = is_signed_op(r_op);

`ifdef MULDIV_EARLY_EXIT_EN
    int unsigned w_shamt;
    assign w_shamt = 32'(r_count) * 32'(STEP_BITS);
    assign w_early = !w_is_div &&
                     ((r_acc[WORD_W-1:0] & ~({WORD_W{1'b1}} << w_shamt)) == '0);
`else
    assign w_early = 1'b0;
`endif

    muldiv_step #(.WORD_W(WORD_W), .STEP_BITS(STEP_BITS)) u_step (
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .i_is_div  (w_is_div),
        .o_acc     (w_step_acc)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= MD_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_calc = 1'b0;
        w_fin  = 1'b0;
        case (r_state)
            MD_IDLE, MD_DONE: begin
                w_next = MD_IDLE;
                if (bus.start) begin
                    w_next = MD_CALC;
                    w_load = 1'b1;
                end
            end
            MD_CALC: begin
                if (r_count == '0) w_next = MD_SIGN;
                else               w_calc = 1'b1;
            end
            MD_SIGN: begin
                w_fin  = 1'b1;
                w_next = MD_DONE;
            end
            default: w_next = MD_IDLE;
        endcase
        if (bus.flush) begin
            w_next = MD_IDLE;
            w_load = 1'b0;
            w_calc = 1'b0;
            w_fin  = 1'b0;
        end
    end

    // Divide-by-zero leaves |A| as remainder; the dividend-sign fix restores the original port_A.
    assign w_neg_res = w_is_signed & (r_sa ^ r_sb);
    assign w_dz      = w_is_div & (r_opnd == '0);
    assign w_prod    = w_neg_res ? -r_acc : r_acc;
    assign w_quo     = w_neg_res ? -r_acc[WORD_W-1:0] : r_acc[WORD_W-1:0];
    assign w_rem     = (w_is_signed & r_sa) ? -r_acc[2*WORD_W-1:WORD_W] : r_acc[2*WORD_W-1:WORD_W];
    assign w_hi      = w_is_div ? w_rem : w_prod[2*WORD_W-1:WORD_W];
    assign w_lo      = w_is_div ? (w_dz ? '1 : w_quo) : w_prod[WORD_W-1:0];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_op       <= MD_MULT;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_count    <= '0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            if (w_load) begin
                r_op    <= bus.md_op;
                r_sa    <= w_ld_signed & bus.port_A[WORD_W-1];
                r_sb    <= w_ld_signed & bus.port_B[WORD_W-1];
                r_opnd  <= w_ld_div ? w_abs_b : w_abs_a;
                r_acc   <= {{WORD_W{1'b0}}, (w_ld_div ? w_abs_a : w_abs_b)};
                r_count <= N_CNT;
            end else if (w_calc) begin
`ifdef MULDIV_EARLY_EXIT_EN
                if (w_early) begin
                    r_acc   <= r_acc >> w_shamt;
                    r_count <= '0;
                end else begin
                    r_acc   <= w_step_acc;
                    r_count <= r_count - 1'b1;
                end
`else
                r_acc   <= w_step_acc;
                r_count <= r_count - 1'b1;
`endif
            end
            if (w_fin) begin
                r_hi       <= w_hi;
                r_lo       <= w_lo;
                r_div_zero <= w_dz;
            end
        end
    end

    assign bus.busy     = (r_state == MD_CALC) || (r_state == MD_SIGN);
    assign bus.done     = (r_state == MD_DONE);
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.div_zero = r_div_zero;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
    import cpu_types_pkg::*;

    localparam int LAT   = 34;
    localparam int LIMIT = 200;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   total = 0;
    int   bad   = 0;

    muldiv_if bus();

    muldiv_unit u_dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        muldiv_op_t op;
        word_t      a;
        word_t      b;
        word_t      hi;
        word_t      lo;
        logic       dz;
    } vec_t;

    function automatic void model(input muldiv_op_t op, input word_t a, input word_t b,
                                  output word_t hi, output word_t lo, output logic dz);
        longint      sa, sb, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        dz = 1'b0;
        case (op)
            MD_MULTU: begin
                u = {32'b0, a} * {32'b0, b};
                {hi, lo} = u;
            end
            MD_MULT: begin
                p = sa * sb;
                {hi, lo} = p;
            end
            default: begin
                if (b == 0) begin
                    hi = a;
                    lo = '1;
                    dz = 1'b1;
                end else if (op == MD_DIVU) begin
                    lo = a / b;
                    hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = a;
                    hi = '0;
                end else begin
                    lo = word_t'(sa / sb);
                    hi = word_t'(sa % sb);
                end
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic launch(input muldiv_op_t op, input word_t a, input word_t b);
        bus.md_op  = op;
        bus.port_A = a;
        bus.port_B = b;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit to);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        to = (bus.done !== 1'b1);
    endtask

    task automatic watch_no_done(input int n, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int    cyc;
        bit    to, seen;
        word_t eh, el;
        logic  ed;
        #12;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++;
            $display("FAIL reset_ctrl busy=%b done=%b want 0 0", bus.busy, bus.done); end
        total++; if (bus.hi !== '0 || bus.lo !== '0 || bus.div_zero !== 1'b0) begin bad++;
            $display("FAIL reset_data hi=%h lo=%h dz=%b want 0", bus.hi, bus.lo, bus.div_zero); end
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        launch(MD_MULT, 32'd5, 32'd7);
        wait_done(cyc, to);
        model(MD_MULT, 32'd5, 32'd7, eh, el, ed);
        total++; if (to || bus.lo !== el || bus.hi !== eh) begin bad++;
            $display("FAIL reset_pre_op timeout=%0d hi=%h lo=%h want %h %h", to, bus.hi, bus.lo, eh, el); end
        tick();
        launch(MD_MULTU, 32'hFFFF_FFFF, 32'h1234_5678);
        repeat (10) tick();
        #2 nRST = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++;
            $display("FAIL reset_mid_ctrl busy=%b done=%b want 0 0", bus.busy, bus.done); end
        total++; if (bus.hi !== '0 || bus.lo !== '0 || bus.div_zero !== 1'b0) begin bad++;
            $display("FAIL reset_mid_data hi=%h lo=%h dz=%b want 0", bus.hi, bus.lo, bus.div_zero); end
        @(negedge CLK);
        nRST = 1'b1;
        watch_no_done(40, seen);
        total++; if (seen || bus.busy !== 1'b0) begin bad++;
            $display("FAIL reset_no_done seen=%0d busy=%b want 0 0", seen, bus.busy); end
    endtask

    task automatic test_directed();
        vec_t v[$];
        int   cyc;
        bit   to;
        v.push_back('{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        v.push_back('{MD_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
        v.push_back('{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        v.push_back('{MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0});
        v.push_back('{MD_DIV,   32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1});
        v.push_back('{MD_MULT,  32'd2,         32'd2,         32'd0,         32'd4,         1'b0});
        v.push_back('{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0});
        v.push_back('{MD_DIVU,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1});
        foreach (v[i]) begin
            launch(v[i].op, v[i].a, v[i].b);
            wait_done(cyc, to);
            total++; if (to) begin bad++;
                $display("FAIL dir%0d_timeout cycles=%0d limit=%0d", i, cyc, LIMIT); end
`ifndef MULDIV_EARLY_EXIT_EN
            total++; if (cyc != LAT) begin bad++;
                $display("FAIL dir%0d_latency got=%0d want=%0d", i, cyc, LAT); end
`endif
            total++; if (bus.hi !== v[i].hi || bus.lo !== v[i].lo || bus.div_zero !== v[i].dz) begin bad++;
                $display("FAIL dir%0d_result hi=%h lo=%h dz=%b want %h %h %b",
                         i, bus.hi, bus.lo, bus.div_zero, v[i].hi, v[i].lo, v[i].dz); end
            tick();
            total++; if (bus.done !== 1'b0 || bus.lo !== v[i].lo) begin bad++;
                $display("FAIL dir%0d_pulse done=%b lo=%h want 0 %h", i, bus.done, bus.lo, v[i].lo); end
        end
    endtask

    task automatic test_random();
        muldiv_op_t op;
        word_t      a, b, eh, el;
        logic       ed;
        int         cyc;
        bit         to;
        for (int i = 0; i < 40; i++) begin
            op = muldiv_op_t'($urandom_range(0, 3));
            a  = ($urandom_range(0, 2) == 0) ? word_t'($urandom_range(0, 50)) : word_t'($urandom);
            case ($urandom_range(0, 5))
                0:       b = '0;
                1, 2:    b = word_t'($urandom_range(1, 100));
                3:       b = -word_t'($urandom_range(1, 100));
                default: b = word_t'($urandom);
            endcase
            model(op, a, b, eh, el, ed);
            launch(op, a, b);
            wait_done(cyc, to);
`ifndef MULDIV_EARLY_EXIT_EN
            total++; if (to || cyc != LAT) begin bad++;
                $display("FAIL rnd%0d_latency got=%0d want=%0d", i, cyc, LAT); end
`else
            total++; if (to) begin bad++;
                $display("FAIL rnd%0d_timeout cycles=%0d", i, cyc); end
`endif
            total++; if (bus.hi !== eh || bus.lo !== el || bus.div_zero !== ed) begin bad++;
                $display("FAIL rnd%0d op=%0d a=%h b=%h hi=%h lo=%h dz=%b want %h %h %b",
                         i, op, a, b, bus.hi, bus.lo, bus.div_zero, eh, el, ed); end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_flush();
        word_t eh, el;
        logic  ed;
        int    cyc;
        bit    to, seen;
        model(MD_MULTU, 32'h0000_1234, 32'h10, eh, el, ed);
        launch(MD_MULTU, 32'h0000_1234, 32'h10);
        wait_done(cyc, to);
        tick();
        launch(MD_DIVU, 32'hDEAD_BEEF, 32'd3);
        repeat (9) tick();
        bus.flush  = 1'b1;
        bus.start  = 1'b1;
        bus.md_op  = MD_MULT;
        tick();
        bus.flush  = 1'b0;
        bus.start  = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++;
            $display("FAIL flush_calc busy=%b done=%b want 0 0", bus.busy, bus.done); end
        watch_no_done(40, seen);
        total++; if (seen || bus.hi !== eh || bus.lo !== el || bus.div_zero !== ed) begin bad++;
            $display("FAIL flush_hold seen=%0d hi=%h lo=%h want 0 %h %h", seen, bus.hi, bus.lo, eh, el); end

        model(MD_MULT, 32'hFFFF_FF00, 32'd77, eh, el, ed);
        launch(MD_MULT, 32'hFFFF_FF00, 32'd77);
        repeat (5) tick();
        launch(MD_DIVU, 32'd1000, 32'd10);
        wait_done(cyc, to);
`ifndef MULDIV_EARLY_EXIT_EN
        total++; if (to || cyc + 6 != LAT) begin bad++;
            $display("FAIL busy_start_latency got=%0d want=%0d", cyc + 6, LAT); end
`endif
        total++; if (to || bus.hi !== eh || bus.lo !== el) begin bad++;
            $display("FAIL busy_start_result hi=%h lo=%h want %h %h", bus.hi, bus.lo, eh, el); end
        watch_no_done(40, seen);
        total++; if (seen) begin bad++;
            $display("FAIL busy_start_queued second done=%0d want 0", seen); end

        launch(MD_DIVU, 32'd50, 32'd7);
        wait_done(cyc, to);
        model(MD_DIVU, 32'd50, 32'd7, eh, el, ed);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        watch_no_done(40, seen);
        total++; if (to || seen || bus.busy !== 1'b0 || bus.lo !== el || bus.hi !== eh) begin bad++;
            $display("FAIL flush_done_start seen=%0d busy=%b lo=%h want 0 0 %h", seen, bus.busy, bus.lo, el); end
    endtask

    task automatic test_back_to_back();
        word_t a1, b1, eh, el;
        logic  ed;
        int    cyc;
        bit    to;
        a1 = word_t'($urandom);
        b1 = word_t'($urandom);
        model(MD_MULTU, a1, b1, eh, el, ed);
        launch(MD_MULTU, a1, b1);
        wait_done(cyc, to);
        total++; if (to || bus.hi !== eh || bus.lo !== el) begin bad++;
            $display("FAIL b2b_first hi=%h lo=%h want %h %h", bus.hi, bus.lo, eh, el); end
        launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, to);
`ifndef MULDIV_EARLY_EXIT_EN
        total++; if (to || cyc != LAT) begin bad++;
            $display("FAIL b2b_latency got=%0d want=%0d", cyc, LAT); end
`endif
        total++; if (to || bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0 || bus.div_zero !== 1'b0) begin bad++;
            $display("FAIL b2b_overflow hi=%h lo=%h dz=%b want 0 80000000 0", bus.hi, bus.lo, bus.div_zero); end
        a1 = word_t'($urandom);
        b1 = word_t'($urandom_range(1, 1000));
        model(MD_DIV, a1, b1, eh, el, ed);
        launch(MD_DIV, a1, b1);
        wait_done(cyc, to);
        total++; if (to || bus.hi !== eh || bus.lo !== el) begin bad++;
            $display("FAIL b2b_third hi=%h lo=%h want %h %h", bus.hi, bus.lo, eh, el); end
        tick();
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.md_op  = MD_MULT;
        bus.port_A = '0;
        bus.port_B = '0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
